// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32I core: opcodes, ALU op classes, forward selects.
package riscv_pkg;

   localparam int REG_AW_DEF = 5;

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'b00,
      ALU_SUB   = 2'b01,
      ALU_FUNCT = 2'b10
   } aluop_e;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_e;

endpackage

// File: rtl/hazard_unit.sv
// Combinational hazard detection: load-use stall, branch flush, operand forwarding.
module hazard_unit
   import riscv_pkg::*;
#(
   parameter int REG_AW = REG_AW_DEF
) (
   input  logic              ValidD,
   input  logic [REG_AW-1:0] Rs1D,
   input  logic [REG_AW-1:0] Rs2D,
   input  logic              ValidE,
   input  logic              RegWriteE,
   input  logic              ResultSrcE,
   input  logic              BranchE,
   input  logic              ZeroE,
   input  logic [REG_AW-1:0] RdE,
   input  logic [REG_AW-1:0] Rs1E,
   input  logic [REG_AW-1:0] Rs2E,
   input  logic              RegWriteM,
   input  logic [REG_AW-1:0] RdM,
   input  logic              RegWriteW,
   input  logic [REG_AW-1:0] RdW,
   output logic              LoadUse,
   output logic              PCSrcE,
   output logic              StallF,
   output logic              StallD,
   output logic              FlushD,
   output logic [1:0]        ForwardAE,
   output logic [1:0]        ForwardBE
);

   function automatic fwd_e fwd_sel(input logic [REG_AW-1:0] rs);
      if (RegWriteM && (RdM != '0) && (RdM == rs))
         return FWD_MEM;
      else if (RegWriteW && (RdW != '0) && (RdW == rs))
         return FWD_WB;
      else
         return FWD_RF;
   endfunction

   // Rs2D is compared even for I-type; the occasional false stall is harmless.
   assign LoadUse = ValidD & ResultSrcE & RegWriteE & (RdE != '0)
                  & ((RdE == Rs1D) | (RdE == Rs2D));
   assign PCSrcE  = ValidE & BranchE & ZeroE;

   // A taken branch squashes the dependent instruction, so it overrides the stall.
   assign StallF  = LoadUse & ~PCSrcE;
   assign StallD  = LoadUse & ~PCSrcE;
   assign FlushD  = PCSrcE;

   assign ForwardAE = fwd_sel(Rs1E);
   assign ForwardBE = fwd_sel(Rs2E);

endmodule

// File: rtl/pipeline_control.sv
// Control-path registers ID/EX, EX/MEM, MEM/WB for the five-stage core,
// with hazard detection and forwarding selects from hazard_unit.
module pipeline_control
   import riscv_pkg::*;
#(
   parameter int REG_AW = REG_AW_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ValidD,
   input  logic              RegWriteD,
   input  logic              ALUSrcD,
   input  logic              MemWriteD,
   input  logic              ResultSrcD,
   input  logic              BranchD,
   input  logic [1:0]        ALUOpD,
   input  logic [REG_AW-1:0] Rs1D,
   input  logic [REG_AW-1:0] Rs2D,
   input  logic [REG_AW-1:0] RdD,
   input  logic              ZeroE,
   output logic              RegWriteE,
   output logic              ALUSrcE,
   output logic              MemWriteE,
   output logic              ResultSrcE,
   output logic              BranchE,
   output logic [1:0]        ALUOpE,
   output logic [REG_AW-1:0] RdE,
   output logic              RegWriteM,
   output logic              MemWriteM,
   output logic              ResultSrcM,
   output logic [REG_AW-1:0] RdM,
   output logic              RegWriteW,
   output logic              ResultSrcW,
   output logic [REG_AW-1:0] RdW,
   output logic              PCSrcE,
   output logic              StallF,
   output logic              StallD,
   output logic              FlushD,
   output logic [1:0]        ForwardAE,
   output logic [1:0]        ForwardBE
);

   logic              vld_p0, regwrite_p0, alusrc_p0, memwrite_p0, resultsrc_p0, branch_p0;
   logic [1:0]        aluop_p0;
   logic [REG_AW-1:0] rd_p0, rs1_p0, rs2_p0;
   logic              vld_p1, regwrite_p1, memwrite_p1, resultsrc_p1;
   logic [REG_AW-1:0] rd_p1;
   logic              vld_p2, regwrite_p2, resultsrc_p2;
   logic [REG_AW-1:0] rd_p2;
   logic              load_use, bubble_e;

   assign bubble_e = ~ValidD | load_use | PCSrcE;

   // ID/EX: loads the decoder word, or a bubble on stall, flush or empty decode
   always_ff @(posedge clk or negedge rst) begin
      if (!rst || bubble_e) begin
         vld_p0       <= 1'b0;
         regwrite_p0  <= 1'b0;
         alusrc_p0    <= 1'b0;
         memwrite_p0  <= 1'b0;
         resultsrc_p0 <= 1'b0;
         branch_p0    <= 1'b0;
         aluop_p0     <= 2'b00;
         rd_p0        <= '0;
         rs1_p0       <= '0;
         rs2_p0       <= '0;
      end else begin
         vld_p0       <= 1'b1;
         regwrite_p0  <= RegWriteD;
         alusrc_p0    <= ALUSrcD;
         memwrite_p0  <= MemWriteD;
         resultsrc_p0 <= ResultSrcD;
         branch_p0    <= BranchD;
         aluop_p0     <= ALUOpD;
         rd_p0        <= RdD;
         rs1_p0       <= Rs1D;
         rs2_p0       <= Rs2D;
      end
   end

   // EX/MEM and MEM/WB: always advance
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_p1       <= 1'b0;
         regwrite_p1  <= 1'b0;
         memwrite_p1  <= 1'b0;
         resultsrc_p1 <= 1'b0;
         rd_p1        <= '0;
         vld_p2       <= 1'b0;
         regwrite_p2  <= 1'b0;
         resultsrc_p2 <= 1'b0;
         rd_p2        <= '0;
      end else begin
         vld_p1       <= vld_p0;
         regwrite_p1  <= regwrite_p0;
         memwrite_p1  <= memwrite_p0;
         resultsrc_p1 <= resultsrc_p0;
         rd_p1        <= rd_p0;
         vld_p2       <= vld_p1;
         regwrite_p2  <= regwrite_p1;
         resultsrc_p2 <= resultsrc_p1;
         rd_p2        <= rd_p1;
      end
   end

   hazard_unit #(.REG_AW(REG_AW)) u_hazard (
      .ValidD     (ValidD),
      .Rs1D       (Rs1D),
      .Rs2D       (Rs2D),
      .ValidE     (vld_p0),
      .RegWriteE  (regwrite_p0),
      .ResultSrcE (resultsrc_p0),
      .BranchE    (branch_p0),
      .ZeroE      (ZeroE),
      .RdE        (rd_p0),
      .Rs1E       (rs1_p0),
      .Rs2E       (rs2_p0),
      .RegWriteM  (regwrite_p1 & vld_p1),
      .RdM        (rd_p1),
      .RegWriteW  (regwrite_p2 & vld_p2),
      .RdW        (rd_p2),
      .LoadUse    (load_use),
      .PCSrcE     (PCSrcE),
      .StallF     (StallF),
      .StallD     (StallD),
      .FlushD     (FlushD),
      .ForwardAE  (ForwardAE),
      .ForwardBE  (ForwardBE)
   );

   assign RegWriteE  = regwrite_p0;
   assign ALUSrcE    = alusrc_p0;
   assign MemWriteE  = memwrite_p0;
   assign ResultSrcE = resultsrc_p0;
   assign BranchE    = branch_p0;
   assign ALUOpE     = aluop_p0;
   assign RdE        = rd_p0;
   assign RegWriteM  = regwrite_p1;
   assign MemWriteM  = memwrite_p1;
   assign ResultSrcM = resultsrc_p1;
   assign RdM        = rd_p1;
   assign RegWriteW  = regwrite_p2;
   assign ResultSrcW = resultsrc_p2;
   assign RdW        = rd_p2;

endmodule

// File: doc/pipeline_control.md
# pipeline_control

Sequences the control path of the five-stage pipelined RISC-V core. It takes the decode-stage control word from the main decoder and carries it through ID/EX, EX/MEM and MEM/WB control registers. It also detects load-use and branch hazards, driving stall and flush to the fetch/decode registers, and produces operand forwarding selects for the execute stage. It sits beside the datapath; the datapath holds only data registers, and this block owns all pipeline control state.

## Interface
Parameters:
- REG_AW, 5, register-address width

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- ValidD  in  1  decode stage holds a real instruction
- RegWriteD, ALUSrcD, MemWriteD, ResultSrcD, BranchD  in  1 each  decoder control bits
- ALUOpD  in  2  decoder ALU op class
- Rs1D, Rs2D, RdD  in  REG_AW each  decode-stage register addresses
- ZeroE  in  1  ALU zero flag, execute stage
- RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE  out  1 each  execute-stage control
- ALUOpE  out  2  execute-stage ALU op class
- RdE  out  REG_AW  execute-stage destination
- RegWriteM, MemWriteM, ResultSrcM  out  1 each  memory-stage control
- RdM  out  REG_AW  memory-stage destination
- RegWriteW, ResultSrcW  out  1 each  writeback control
- RdW  out  REG_AW  writeback destination
- PCSrcE  out  1  branch taken, redirect PC
- StallF, StallD  out  1 each  hold PC / IF-ID register
- FlushD  out  1  clear IF-ID register
- ForwardAE, ForwardBE  out  2 each  ALU operand select: 00 regfile, 01 writeback result, 10 memory-stage ALU result

## Operation
- Three control registers: E (from D), M (from E), W (from M). Each also holds a valid bit. E additionally holds Rs1E and Rs2E. M and W hold only the fields listed.
- Bubble is defined as all control bits 0, Rd 0 and valid 0.
- Load-use: LoadUse = ValidD & ResultSrcE & RegWriteE & (RdE != 0) & (RdE == Rs1D | RdE == Rs2D). Compare Rs2D even for I-type; the false stall is accepted.
  - While LoadUse: StallF = StallD = 1, and E loads a bubble next edge.
- Branch: PCSrcE = ValidE & BranchE & ZeroE.
  - While PCSrcE: FlushD = 1, and E loads a bubble next edge.
- Simultaneous LoadUse and PCSrcE: branch wins. StallF = StallD = 0, FlushD = 1, E loads a bubble.
- M and W never stall or flush. They always advance.
- ForwardAE:
  - 10 if RegWriteM & RdM != 0 & RdM == Rs1E;
  - else 01 if RegWriteW & RdW != 0 & RdW == Rs1E;
  - else 00.
  - ForwardBE is the same rule using Rs2E. The memory stage takes priority over writeback.
- Writes to x0 never trigger forwarding or stall.
- ValidD = 0 loads a bubble into E, identical to a flush.

## Timing
- Reset (rst low, asynchronous): all E/M/W registers clear to bubble.
  - Hence every registered output is 0, and PCSrcE, StallF, StallD, FlushD, ForwardAE and ForwardBE are 0.
  - Reset mid-instruction discards all in-flight control without completion.
- Deassertion takes effect on the first rising edge with rst high.
- Latency: a control word at D appears at E after 1 edge, M after 2, W after 3.
- Stall, flush, PCSrcE and forward selects are combinational from the current register contents and D inputs. They are valid within the same cycle and are never registered.
- A load followed by a dependent instruction costs exactly one bubble cycle. The next cycle selects ForwardXE = 01 from W.
- A taken branch costs two squashed instructions: the one in D (via FlushD) and the one entering E (via the bubble).
- Back-to-back branches: a bubbled E has ValidE = 0, so no second redirect is generated from it.

## Structure
- Shared package riscv_pkg holds:
  - the opcode constants used by the decoder;
  - the ALUOp encodings (00 add, 01 sub/branch, 10 funct decode);
  - the forward-select encodings FWD_RF = 00, FWD_WB = 01, FWD_MEM = 10;
  - the REG_AW default.
- One combinational sub-module, hazard_unit, computes LoadUse, the stall/flush outputs and the forward selects. pipeline_control owns the three stage registers and instantiates hazard_unit.

## Test plan
- Reset: hold rst low for 3 cycles with random D inputs -> all outputs 0. Release -> an R-type in D (RegWriteD = 1, ALUOpD = 10, RdD = 5) gives RegWriteE = 1 and RdE = 5 one edge later, then RdM = 5, then RdW = 5.
- Load-use: lw x6 in E (ResultSrcE = 1, RdE = 6); add with Rs1D = 6 -> StallF = StallD = 1 that cycle, next E is a bubble, the following cycle ForwardAE = 01.
- Forward priority: RdM = 7 and RdW = 7 both with RegWrite, Rs2E = 7 -> ForwardBE = 10. With RdM = 0 instead -> ForwardBE = 01. With Rs2E = 0 -> ForwardBE = 00.
- Taken branch: BranchE = 1, ZeroE = 1, ValidE = 1 -> PCSrcE = 1 and FlushD = 1. Next cycle RegWriteE = MemWriteE = 0 and PCSrcE = 0.
- Simultaneous: taken branch in E plus a load-use condition in D -> PCSrcE = 1, FlushD = 1, StallF = StallD = 0.
- Asynchronous reset mid-stream: pull rst low between edges with a store in M -> MemWriteM drops to 0 immediately, without waiting for an edge.
